vx_ttu_ctrl: RTL

Master-side sequencer for the interrupt controller's Thread Transfer Unit. It arbitrates pending hardware IRQ lines round-robin and finds a warp with an available thread by scanning warps. It then drives the ttu_master signal group: borrow one thread for the ISR, wait for ISR completion or a watchdog timeout, and hand back the saved thread mask/PC for restore. It sits inside the core next to the warp scheduler, which implements the ttu_slave side.

---
 rtl/vx_ttu_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/vx_ttu_ctrl.sv
// Thread Transfer Unit master sequencer: round-robin IRQ arbitration, warp scan for a
// free thread, ISR run with watchdog, and hand-back of the saved mask/PC for restore.
module vx_ttu_ctrl #(
    parameter int               NUM_IRQ     = 4,
    parameter int               NUM_WARPS   = 4,
    parameter int               NUM_THREADS = 4,
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  ISR_BASE    = 32'h8000_0000,
    parameter logic [XLEN-1:0]  ISR_STRIDE  = 32'h0000_0100,
    parameter int               TIMEOUT     = 1024,
    localparam int              NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int              NT_WIDTH    = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_IRQ-1:0]     irq_req,
    input  logic [NUM_IRQ-1:0]     irq_mask,
    output logic [NUM_IRQ-1:0]     irq_ack,
    output logic [NUM_IRQ-1:0]     irq_drop,
    output logic                   timeout_err,
    output logic                   busy,
    output logic [2:0]             state,
    output logic [XLEN-1:0]        ISR_PC,
    output logic [NW_WIDTH-1:0]    wid,
    output logic [NT_WIDTH-1:0]    tid,
    input  logic                   pipeline_drained,
    input  logic                   thread_found,
    input  logic [NUM_THREADS-1:0] current_thread_mask,
    input  logic [XLEN-1:0]        current_PC,
    input  logic                   ISR_done,
    output logic [NUM_THREADS-1:0] interrupted_thread_mask,
    output logic [XLEN-1:0]        interrupted_PC
);
    localparam int IRQ_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRAIN   = 3'd1,
        S_SCAN    = 3'd2,
        S_SWAP    = 3'd3,
        S_RUN     = 3'd4,
        S_RESTORE = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic [IRQ_W-1:0]       irq_id_q, irq_id_d;
    logic [IRQ_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [XLEN-1:0]        isr_pc_q, isr_pc_d;
    logic [NW_WIDTH-1:0]    wid_q, wid_d;
    logic [NT_WIDTH-1:0]    tid_q, tid_d;
    logic [NUM_THREADS-1:0] imask_q, imask_d;
    logic [XLEN-1:0]        ipc_q, ipc_d;
    logic [WD_W-1:0]        watchdog_q, watchdog_d;
    logic                   drop_q, drop_d;
    logic                   timeout_q, timeout_d;
    logic                   busy_q;

    logic [NUM_IRQ-1:0]     pending_s;
    logic                   grant_valid_s;
    logic [IRQ_W-1:0]       grant_id_s;
    logic [NT_WIDTH-1:0]    low_tid_s;
    logic [NUM_IRQ-1:0]     irq_onehot_s;

    // Successor of a line index in the round-robin ring.
    function automatic logic [IRQ_W-1:0] next_rr(input logic [IRQ_W-1:0] id);
        return (id == IRQ_W'(NUM_IRQ - 1)) ? '0 : id + IRQ_W'(1);
    endfunction

    assign pending_s = irq_req & irq_mask;

    // Round-robin pick: first pending line at or after rr_ptr, wrapping.
    always_comb begin
        logic [IRQ_W:0]   sum_v;
        logic [IRQ_W-1:0] idx_v;
        grant_valid_s = 1'b0;
        grant_id_s    = '0;
        sum_v         = '0;
        idx_v         = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            sum_v = {1'b0, rr_ptr_q} + (IRQ_W + 1)'(i);
            idx_v = (sum_v >= (IRQ_W + 1)'(NUM_IRQ)) ? IRQ_W'(sum_v - (IRQ_W + 1)'(NUM_IRQ))
                                                     : IRQ_W'(sum_v);
            grant_valid_s = grant_valid_s | pending_s[idx_v];
            grant_id_s    = pending_s[idx_v] ? idx_v : grant_id_s;
        end
    end

    // Lowest set bit of the slave's active mask selects the borrowed thread.
    always_comb begin
        low_tid_s = '0;
        for (int t = NUM_THREADS - 1; t >= 0; t--) begin
            low_tid_s = current_thread_mask[t] ? NT_WIDTH'(t) : low_tid_s;
        end
    end

    // One-hot decode of the latched IRQ for the ack/drop pulses.
    always_comb begin
        irq_onehot_s = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            irq_onehot_s[k] = (irq_id_q == IRQ_W'(k));
        end
    end

    // Sequencer next-state and datapath latch decisions.
    always_comb begin
        state_d    = state_q;
        irq_id_d   = irq_id_q;
        rr_ptr_d   = rr_ptr_q;
        isr_pc_d   = isr_pc_q;
        wid_d      = wid_q;
        tid_d      = tid_q;
        imask_d    = imask_q;
        ipc_d      = ipc_q;
        watchdog_d = watchdog_q;
        drop_d     = 1'b0;
        timeout_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_valid_s) begin
                    irq_id_d = grant_id_s;
                    isr_pc_d = ISR_BASE + (XLEN'(grant_id_s) * ISR_STRIDE);
                    wid_d    = '0;
                    state_d  = S_DRAIN;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (!pipeline_drained) begin
                    state_d = S_DRAIN;
                end else if (thread_found) begin
                    imask_d = current_thread_mask;
                    ipc_d   = current_PC;
                    tid_d   = low_tid_s;
                    state_d = S_SWAP;
                end else if (wid_q == NW_WIDTH'(NUM_WARPS - 1)) begin
                    drop_d   = 1'b1;
                    rr_ptr_d = next_rr(irq_id_q);
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                wid_d   = wid_q + NW_WIDTH'(1);
                state_d = S_DRAIN;
            end
            S_SWAP: begin
                watchdog_d = '0;
                state_d    = S_RUN;
            end
            S_RUN: begin
                watchdog_d = watchdog_q + WD_W'(1);
                if (ISR_done) begin
                    state_d = S_RESTORE;
                end else if (watchdog_q == WD_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_RESTORE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RESTORE: begin
                rr_ptr_d = next_rr(irq_id_q);
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            irq_id_q   <= '0;
            rr_ptr_q   <= '0;
            isr_pc_q   <= '0;
            wid_q      <= '0;
            tid_q      <= '0;
            imask_q    <= '0;
            ipc_q      <= '0;
            watchdog_q <= '0;
            drop_q     <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            irq_id_q   <= irq_id_d;
            rr_ptr_q   <= rr_ptr_d;
            isr_pc_q   <= isr_pc_d;
            wid_q      <= wid_d;
            tid_q      <= tid_d;
            imask_q    <= imask_d;
            ipc_q      <= ipc_d;
            watchdog_q <= watchdog_d;
            drop_q     <= drop_d;
            timeout_q  <= timeout_d;
            busy_q     <= (state_d != S_IDLE);
        end
    end

    assign irq_ack                 = (state_q == S_RESTORE) ? irq_onehot_s : '0;
    assign irq_drop                = drop_q ? irq_onehot_s : '0;
    assign timeout_err             = timeout_q;
    assign busy                    = busy_q;
    assign state                   = state_q;
    assign ISR_PC                  = isr_pc_q;
    assign wid                     = wid_q;
    assign tid                     = tid_q;
    assign interrupted_thread_mask = imask_q;
    assign interrupted_PC          = ipc_q;

endmodule
